sad_min_tracker: RTL and testbench

//  Sits directly downstream of the SAD adder tree in the integer ME datapath.

---
 rtl/sad_min_tracker.sv | 131 +++++++++++++
 tb/tb_sad_min_tracker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD and its winning MV for each of the nine large partitions
// over one motion-search window; done pulses when the final results are valid.
module sad_min_tracker #(
  parameter int MV_W  = 7,
  parameter int CNT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sad_valid,
  input  logic                 sad_last,
  input  logic [MV_W-1:0]      mv_x,
  input  logic [MV_W-1:0]      mv_y,
  input  logic [63:0]          sad16x16,
  input  logic [33:0]          sad16x32,
  input  logic [33:0]          sad32x16,
  input  logic [17:0]          sad32x32,
  output logic [63:0]          best16x16,
  output logic [33:0]          best16x32,
  output logic [33:0]          best32x16,
  output logic [17:0]          best32x32,
  output logic [18*MV_W-1:0]   best_mv,
  output logic [CNT_W-1:0]     cand_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int SLOTS = 9;
  localparam int PW    = 2 * MV_W;

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  state_t           state_p1;
  logic [17:0]      cand_p0 [SLOTS];
  logic [PW-1:0]    mv_p0;
  logic [17:0]      best_p1 [SLOTS];
  logic [PW-1:0]    mv_p1   [SLOTS];
  logic [CNT_W-1:0] cnt_p1;
  logic             busy_p1;
  logic             done_p1;

  // "No winner yet" value: all-ones at the native width of each partition's SAD.
  function automatic logic [17:0] sad_ones(input int k);
    if (k < 4)      return 18'h0FFFF;
    else if (k < 8) return 18'h1FFFF;
    else            return 18'h3FFFF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // p0: unpack candidate SADs into one zero-extended slot array
  always_comb begin
    for (int k = 0; k < 4; k++) cand_p0[k] = {2'b00, sad16x16[16*k +: 16]};
    for (int k = 0; k < 2; k++) begin
      cand_p0[4+k] = {1'b0, sad16x32[17*k +: 17]};
      cand_p0[6+k] = {1'b0, sad32x16[17*k +: 17]};
    end
    cand_p0[8] = sad32x32;
  end

  assign mv_p0 = {mv_y, mv_x};

  // p1: registered running minima, window control and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      cnt_p1   <= '0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        best_p1[k] <= sad_ones(k);
        mv_p1[k]   <= '0;
      end
    end else begin
      done_p1 <= 1'b0;
      if (start) begin
        for (int k = 0; k < SLOTS; k++) begin
          best_p1[k] <= sad_valid ? cand_p0[k] : sad_ones(k);
          mv_p1[k]   <= sad_valid ? mv_p0 : '0;
        end
        cnt_p1 <= {{(CNT_W-1){1'b0}}, sad_valid};
        if (sad_valid && sad_last) begin
          state_p1 <= DONE;
          busy_p1  <= 1'b0;
          done_p1  <= 1'b1;
        end else begin
          state_p1 <= TRACK;
          busy_p1  <= 1'b1;
        end
      end else begin
        case (state_p1)
          TRACK: begin
            if (sad_valid) begin
              // Strict less-than keeps the first-found candidate on ties.
              for (int k = 0; k < SLOTS; k++) begin
                if (cand_p0[k] < best_p1[k]) begin
                  best_p1[k] <= cand_p0[k];
                  mv_p1[k]   <= mv_p0;
                end
              end
              cnt_p1 <= sat_inc(cnt_p1);
              if (sad_last) begin
                state_p1 <= DONE;
                busy_p1  <= 1'b0;
                done_p1  <= 1'b1;
              end
            end
          end
          DONE:    state_p1 <= IDLE;
          default: state_p1 <= IDLE;
        endcase
      end
    end
  end

  assign best16x16 = {best_p1[3][15:0], best_p1[2][15:0], best_p1[1][15:0], best_p1[0][15:0]};
  assign best16x32 = {best_p1[5][16:0], best_p1[4][16:0]};
  assign best32x16 = {best_p1[7][16:0], best_p1[6][16:0]};
  assign best32x32 = best_p1[8];
  assign cand_cnt  = cnt_p1;
  assign busy      = busy_p1;
  assign done      = done_p1;

  always_comb begin
    best_mv = '0;
    for (int k = 0; k < SLOTS; k++) best_mv[k*PW +: PW] = mv_p1[k];
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker: a window-level model predicts final
// per-partition minima at each sad_last; a monitor checks them on every done pulse.
module tb_sad_min_tracker;

  localparam int MV_W  = 7;
  localparam int CNT_W = 12;
  localparam int PW    = 2 * MV_W;

  typedef struct packed {
    logic [8:0][17:0] s;
    logic [PW-1:0]    mv;
  } cand_t;

  typedef struct packed {
    logic [63:0]      b16;
    logic [33:0]      b1632;
    logic [33:0]      b3216;
    logic [17:0]      b32;
    logic [9*PW-1:0]  mv;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, sad_valid, sad_last;
  logic [MV_W-1:0]   mv_x, mv_y;
  logic [63:0]       sad16x16;
  logic [33:0]       sad16x32, sad32x16;
  logic [17:0]       sad32x32;
  logic [63:0]       best16x16;
  logic [33:0]       best16x32, best32x16;
  logic [17:0]       best32x32;
  logic [18*MV_W-1:0] best_mv;
  logic [CNT_W-1:0]  cand_cnt;
  logic              busy, done;

  sad_min_tracker #(.MV_W(MV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sad_valid(sad_valid), .sad_last(sad_last),
    .mv_x(mv_x), .mv_y(mv_y), .sad16x16(sad16x16), .sad16x32(sad16x32),
    .sad32x16(sad32x16), .sad32x32(sad32x32), .best16x16(best16x16),
    .best16x32(best16x32), .best32x16(best32x16), .best32x32(best32x32),
    .best_mv(best_mv), .cand_cnt(cand_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  cand_t            win[$];
  exp_t             expq[$];
  bit               in_win;
  logic [8:0][17:0] cs;
  logic [MV_W-1:0]  cmx, cmy;
  int               n_vec = 0;
  int               n_err = 0;

  function automatic logic [17:0] ones(input int k);
    if (k < 4)      return 18'h0FFFF;
    else if (k < 8) return 18'h1FFFF;
    else            return 18'h3FFFF;
  endfunction

  // Final result of the current window: smallest value per partition, earliest on ties.
  function automatic exp_t model_final();
    exp_t        e;
    logic [17:0] b [9];
    logic [PW-1:0] m [9];
    for (int k = 0; k < 9; k++) begin
      b[k] = ones(k);
      m[k] = '0;
      foreach (win[i]) if (win[i].s[k] < b[k]) begin b[k] = win[i].s[k]; m[k] = win[i].mv; end
    end
    e.b16   = {b[3][15:0], b[2][15:0], b[1][15:0], b[0][15:0]};
    e.b1632 = {b[5][16:0], b[4][16:0]};
    e.b3216 = {b[7][16:0], b[6][16:0]};
    e.b32   = b[8];
    e.mv    = '0;
    for (int k = 0; k < 9; k++) e.mv[k*PW +: PW] = m[k];
    e.cnt   = (win.size() > 4095) ? 12'hFFF : CNT_W'(win.size());
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rand_cand(input bit tie);
    for (int k = 0; k < 9; k++)
      cs[k] = tie ? 18'($urandom_range(0, 7)) : (18'($urandom) & ones(k));
    cmx = MV_W'($urandom);
    cmy = MV_W'($urandom);
  endtask

  // One clock of stimulus; the model tracks what the window contains after this edge.
  task automatic cyc(input bit st, input bit v, input bit l);
    cand_t c;
    @(posedge clk); #1;
    start = st; sad_valid = v; sad_last = l; mv_x = cmx; mv_y = cmy;
    sad16x16 = {cs[3][15:0], cs[2][15:0], cs[1][15:0], cs[0][15:0]};
    sad16x32 = {cs[5][16:0], cs[4][16:0]};
    sad32x16 = {cs[7][16:0], cs[6][16:0]};
    sad32x32 = cs[8];
    if (st) begin win.delete(); in_win = 1'b1; end
    if (in_win && v) begin
      c.s = cs; c.mv = {cmy, cmx};
      win.push_back(c);
      if (l) begin expq.push_back(model_final()); in_win = 1'b0; end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_best32x32"}, best32x32, 18'h3FFFF);
    chk({tag, "_best16x16"}, best16x16, {64{1'b1}});
    chk({tag, "_best_mv"}, best_mv, 0);
    chk({tag, "_cand_cnt"}, cand_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (expq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending window");
      end else begin
        e = expq.pop_front();
        chk("best16x16", best16x16, e.b16);
        chk("best16x32", best16x32, e.b1632);
        chk("best32x16", best32x16, e.b3216);
        chk("best32x32", best32x32, e.b32);
        chk("best_mv", best_mv, e.mv);
        chk("cand_cnt", cand_cnt, e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 0; sad_valid = 0; sad_last = 0; mv_x = 0; mv_y = 0;
    sad16x16 = 0; sad16x32 = 0; sad32x16 = 0; sad32x32 = 0;
    cs = '0; cmx = 0; cmy = 0; in_win = 0;
    #12;
    reset_checks("t1");
    @(posedge clk); #1 rst_n = 1'b1;

    // T2: single window, tie on 300 keeps the earlier MV
    rand_cand(0);
    cyc(1, 0, 0);
    rand_cand(0); cs[8] = 500; cmx = 7'd1;  cmy = 7'd2; cyc(0, 1, 0);
    rand_cand(0); cs[8] = 300; cmx = 7'h7D; cmy = 7'd4; cyc(0, 1, 0);
    rand_cand(0); cs[8] = 300; cmx = 7'd5;  cmy = 7'd5; cyc(0, 1, 1);
    chk("t2_busy_track", busy, 1);
    cs = '0; cyc(0, 1, 0);
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    chk("t2_hold_best32x32", best32x32, 300);
    chk("t2_hold_slot8", best_mv[8*PW +: PW], {7'd4, 7'h7D});
    chk("t2_hold_cnt", cand_cnt, 3);
    chk("t2_idle_busy", busy, 0);

    // T3: partitions pick winners independently
    cyc(1, 0, 0);
    for (int k = 0; k < 9; k++) cs[k] = 1000;
    cs[0] = 10; cs[3] = 900; cs[8] = 700; cmx = 7'd2;  cmy = 7'd3;  cyc(0, 1, 0);
    cs[0] = 20; cs[3] = 5;   cs[8] = 600; cmx = 7'h7F; cmy = 7'h7E; cyc(0, 1, 0);
    for (int k = 0; k < 9; k++) cs[k] = 800;
    cs[8] = 650; cmx = 7'd9; cmy = 7'd9; cyc(0, 1, 1);
    cyc(0, 0, 0);
    chk("t3_slot0", best_mv[0 +: PW], {7'd3, 7'd2});
    chk("t3_slot3", best_mv[3*PW +: PW], {7'h7E, 7'h7F});
    chk("t3_best32x32", best32x32, 600);

    // T4: beat in IDLE ignored, start with a candidate loads it as first winner
    for (int k = 0; k < 9; k++) cs[k] = 5;
    cmx = 7'd11; cmy = 7'd12; cyc(0, 1, 0);
    cs = '0; cmx = 0; cmy = 0; cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("t4_cnt", cand_cnt, 1);
    chk("t4_best32x32", best32x32, 0);
    chk("t4_busy", busy, 1);
    rand_cand(0); cyc(0, 1, 1);
    cyc(0, 0, 0);

    // T5: restart mid-window
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) begin rand_cand(0); cyc(0, 1, 0); end
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("t5_best32x32", best32x32, 18'h3FFFF);
    chk("t5_best16x16", best16x16, {64{1'b1}});
    chk("t5_cnt", cand_cnt, 0);
    chk("t5_done", done, 0);
    for (int i = 0; i < 3; i++) begin rand_cand(0); cyc(0, 1, i == 2); end
    cyc(0, 0, 0);

    // T6: reset pulse mid-window, then a clean window
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) begin rand_cand(0); cyc(0, 1, 0); end
    @(posedge clk); #1;
    rst_n = 1'b0; start = 0; sad_valid = 0; sad_last = 0;
    win.delete(); in_win = 0;
    #1 reset_checks("t6");
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1, 0, 0);
    for (int i = 0; i < 4; i++) begin rand_cand(0); cyc(0, 1, i == 3); end
    cyc(0, 0, 0);

    // Randomized windows: gaps, ties, stray sad_last, start with a candidate
    for (int w = 0; w < 40; w++) begin
      int len;
      len = $urandom_range(1, 20);
      rand_cand($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) cyc(1, 1, len == 1);
      else cyc(1, 0, 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) cyc(0, 0, $urandom_range(0, 1) == 1);
        rand_cand($urandom_range(0, 1) == 1);
        cyc(0, 1, i == len - 1);
      end
      repeat ($urandom_range(0, 3)) cyc(0, $urandom_range(0, 1) == 1, 0);
    end

    // Counter saturation over a long window
    cyc(1, 0, 0);
    for (int i = 0; i < 4100; i++) begin rand_cand(0); cyc(0, 1, i == 4099); end

    repeat (4) cyc(0, 0, 0);
    chk("windows_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
